systolic_mac_pe: RTL and testbench
==================================

Name: systolic_mac_pe

Overview:
- Parametrised processing element for an output-stationary systolic array.
- Forwards A east and B south with one-cycle registration and per-operand valid, so bubbles are allowed.
- Accumulates A×B products in signed or unsigned mode, with optional saturation.
- Hands finished dot-products to a per-column drain shift chain; a tile clear/last marker travels with the A operand.

Parameters:
- DATA_WIDTH, 8, width of the A and B operands.
- ACC_WIDTH, 20, accumulator/result width; must be >= 2*DATA_WIDTH.
- SIGNED, 0, 1 = operands and accumulator are two's complement; 0 = unsigned.
- SATURATE, 0, 1 = clamp on accumulator overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_in  in  DATA_WIDTH  operand A from the west.
- a_valid_in  in  1  a_in valid.
- a_first_in  in  1  marks the first k-element of a dot-product; qualified by a_valid_in.
- a_last_in  in  1  marks the last k-element; qualified by a_valid_in.
- b_in  in  DATA_WIDTH  operand B from the north.
- b_valid_in  in  1  b_in valid.
- a_out, a_valid_out, a_first_out, a_last_out  out  DATA_WIDTH,1,1,1  registered copies of the A-side inputs, to the east.
- b_out, b_valid_out  out  DATA_WIDTH,1  registered copies of the B-side inputs, to the south.
- drain_shift  in  1  column-wide drain enable.
- drain_in  in  ACC_WIDTH  result from the PE above.
- drain_valid_in  in  1  drain_in valid.
- result_out  out  ACC_WIDTH  held result register, to the PE below.
- result_valid_out  out  1  result_out valid.
- overflow  out  1  sticky accumulator overflow/saturation flag.
- overrun  out  1  sticky lost-result flag.

Behaviour:
- Reset (reset=0, async): all registers 0.
  - All outputs 0; state IDLE.
- Stage 1 (every edge): a_reg/a_valid/a_first/a_last <= A-side inputs; b_reg/b_valid <= B-side inputs.
  - Forwarding latency is exactly 1 cycle, independent of validity.
- Stage 2 fires only when a_valid_reg & b_valid_reg.
  - p = a_reg*b_reg: 2*DATA_WIDTH bits, signed when SIGNED=1; then sign/zero-extend to ACC_WIDTH+1 bits.
  - sum = (a_first_reg ? 0 : acc) + p.
  - A pair with one side valid and the other not is a bubble: the accumulator holds.
- Overflow detection: sum is outside the ACC_WIDTH range.
  - SATURATE=1: acc <= max or min (the unsigned max is all ones; the unsigned min is 0).
  - SATURATE=0: acc <= sum truncated.
  - Either way, overflow <= 1.
  - overflow clears only on reset or a fire with a_first_reg=1 that does not itself overflow.
- States:
  - IDLE -> ACCUM on a fire with a_first_reg=1.
  - ACCUM -> ACCUM on fires with a_last_reg=0.
  - Any state -> IDLE on a fire with a_last_reg=1; this is the capture.
  - A fire in IDLE without a_first_reg still accumulates into the stale acc; no error is raised.
  - first and last on the same pair form a single-element product.
- Capture: on the firing edge, result_out <= final acc value and result_valid_out <= 1.
  - Result latency from a_in/b_in of the last pair is 2 edges.
- Drain with no capture: when drain_shift=1, result_out <= drain_in and result_valid_out <= drain_valid_in.
  - The old value is consumed below in the same edge.
- Capture with drain_shift=0 while result_valid_out=1: the result is overwritten and overrun <= 1.
- Capture with drain_shift=1: the old result shifts out; result_out <= capture.
  - If drain_valid_in=1, that upstream value is dropped and overrun <= 1.
- drain_shift=0 and no capture: result registers hold.
- overrun clears only on reset.
- Reset asserted mid-accumulation discards acc, result and all flags immediately.

Test Plan:
- Reset release, then SIGNED=0 pairs (3,4),(5,6),(7,8) with first on pair 1 and last on pair 3.
  - Required: result_out=98, result_valid_out=1 two edges after pair 3; a_out/b_out echo each input one cycle later.
- Bubbles: same stream with b_valid_in=0 on alternate cycles, holding values.
  - Required: still 98; no extra accumulation during bubbles.
- SIGNED=1, DATA_WIDTH=8: pairs (-128,-128),(-1,5), first plus last.
  - Required: 16379; then a single pair (127,-1) with first and last gives -127.
- SATURATE=1, ACC_WIDTH=16, unsigned: 2 pairs (255,255) then (255,255).
  - Required: 130050 exceeds 65535, so the result is 65535 and overflow=1.
  - A subsequent first-pair (1,1) gives result 1; overflow clears.
- Drain: capture 98, then drain_shift=1 with drain_in=0x55, drain_valid_in=1.
  - Required: result_out=0x55, valid=1.
  - Next capture coinciding with drain_shift and drain_valid_in=1 gives overrun=1.
- Assert reset for 1 cycle between pairs 2 and 3 of the first stream.
  - Required: all outputs read 0 asynchronously, state IDLE, no result_valid afterwards.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element: forwards A east / B south,
// accumulates A*B per dot-product, and hands results to a per-column drain chain.
//   state | meaning
//   IDLE  | no dot-product open; waiting for a first-marked pair
//   ACCUM | dot-product open; accumulating until a last-marked pair
module systolic_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  input  logic                  a_first_in,
  input  logic                  a_last_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_valid_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  output logic                  a_first_out,
  output logic                  a_last_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_valid_out,
  input  logic                  drain_shift,
  input  logic [ACC_WIDTH-1:0]  drain_in,
  input  logic                  drain_valid_in,
  output logic [ACC_WIDTH-1:0]  result_out,
  output logic                  result_valid_out,
  output logic                  overflow,
  output logic                  overrun
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int SW  = ACC_WIDTH + 1;
  localparam bit SGN = (SIGNED != 0);
  localparam bit SAT = (SATURATE != 0);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = SGN ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = SGN ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  a_valid_q, a_first_q, a_last_q, b_valid_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, res_q, res_d;
  logic                  ovf_q, ovf_d, rv_q, rv_d, ovr_q, ovr_d;
  state_e                state_q, state_d;
  logic [PW-1:0]         prod;
  logic [SW-1:0]         prod_x, base_x, sum;
  logic                  fire, sum_ovf, capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      b_q       <= '0;
      b_valid_q <= 1'b0;
    end else begin
      a_q       <= a_in;
      a_valid_q <= a_valid_in;
      a_first_q <= a_first_in;
      a_last_q  <= a_last_in;
      b_q       <= b_in;
      b_valid_q <= b_valid_in;
    end
  end

  assign a_out       = a_q;
  assign a_valid_out = a_valid_q;
  assign a_first_out = a_first_q;
  assign a_last_out  = a_last_q;
  assign b_out       = b_q;
  assign b_valid_out = b_valid_q;

  assign fire = a_valid_q & b_valid_q;

  // One guard bit above the accumulator is enough since ACC_WIDTH >= 2*DATA_WIDTH.
  always_comb begin
    if (SGN)
      prod = $signed({{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q}) *
             $signed({{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q});
    else
      prod = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
    prod_x  = SGN ? {{(SW-PW){prod[PW-1]}}, prod} : {{(SW-PW){1'b0}}, prod};
    base_x  = a_first_q ? '0 : {(SGN ? acc_q[ACC_WIDTH-1] : 1'b0), acc_q};
    sum     = base_x + prod_x;
    sum_ovf = SGN ? (sum[SW-1] ^ sum[SW-2]) : sum[SW-1];
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (fire) begin
      if (sum_ovf) begin
        ovf_d = 1'b1;
        if (SAT)
          acc_d = (SGN && sum[SW-1]) ? ACC_MIN : ACC_MAX;
        else
          acc_d = sum[ACC_WIDTH-1:0];
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
        if (a_first_q) ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fire) begin
      if (a_last_q)       state_d = IDLE;
      else if (a_first_q) state_d = ACCUM;
    end
  end

  always_comb begin
    capture = fire & a_last_q;
  end

  // A capture wins over the drain; whatever it displaces is recorded as overrun.
  always_comb begin
    res_d = res_q;
    rv_d  = rv_q;
    ovr_d = ovr_q;
    if (capture) begin
      res_d = acc_d;
      rv_d  = 1'b1;
      if (drain_shift ? drain_valid_in : rv_q) ovr_d = 1'b1;
    end else if (drain_shift) begin
      res_d = drain_in;
      rv_d  = drain_valid_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      res_q <= '0;
      rv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
      rv_q  <= rv_d;
      ovr_q <= ovr_d;
    end
  end

  assign result_out       = res_q;
  assign result_valid_out = rv_q;
  assign overflow         = ovf_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: three configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed checks.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  a_in = '0, b_in = '0;
  logic        a_valid_in = 0, a_first_in = 0, a_last_in = 0, b_valid_in = 0;
  logic        drain_shift = 0, drain_valid_in = 0;
  logic [19:0] drain_in = '0;

  logic [7:0]  a_out0, b_out0, a_out1, b_out1, a_out2, b_out2;
  logic        av0, af0, al0, bv0, av1, af1, al1, bv1, av2, af2, al2, bv2;
  logic [19:0] r0, r1;
  logic [15:0] r2;
  logic        rv0, rv1, rv2, ovf0, ovf1, ovf2, ovr0, ovr1, ovr2;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(0)) u_uns (
    .clk(clk), .reset(reset), .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in),
    .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out0),
    .a_valid_out(av0), .a_first_out(af0), .a_last_out(al0), .b_out(b_out0), .b_valid_out(bv0),
    .drain_shift(drain_shift), .drain_in(drain_in), .drain_valid_in(drain_valid_in),
    .result_out(r0), .result_valid_out(rv0), .overflow(ovf0), .overrun(ovr0));

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(0)) u_sgn (
    .clk(clk), .reset(reset), .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in),
    .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out1),
    .a_valid_out(av1), .a_first_out(af1), .a_last_out(al1), .b_out(b_out1), .b_valid_out(bv1),
    .drain_shift(drain_shift), .drain_in(drain_in), .drain_valid_in(drain_valid_in),
    .result_out(r1), .result_valid_out(rv1), .overflow(ovf1), .overrun(ovr1));

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in),
    .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out2),
    .a_valid_out(av2), .a_first_out(af2), .a_last_out(al2), .b_out(b_out2), .b_valid_out(bv2),
    .drain_shift(drain_shift), .drain_in(drain_in[15:0]), .drain_valid_in(drain_valid_in),
    .result_out(r2), .result_valid_out(rv2), .overflow(ovf2), .overrun(ovr2));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: accumulator held as a mathematical integer per configuration.
  int          cfg_w  [3] = '{20, 20, 16};
  bit          cfg_sg [3] = '{1'b0, 1'b1, 1'b0};
  bit          cfg_st [3] = '{1'b0, 1'b0, 1'b1};
  longint      m_acc  [3];
  logic [19:0] m_res  [3];
  bit          m_rv [3], m_ovf [3], m_ovr [3];
  logic [7:0]  s_a, s_b;
  bit          s_av, s_af, s_al, s_bv;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_acc[c] = 0; m_res[c] = '0; m_rv[c] = 0; m_ovf[c] = 0; m_ovr[c] = 0;
    end
    s_a = '0; s_b = '0; s_av = 0; s_af = 0; s_al = 0; s_bv = 0;
  endtask

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      longint modv, lo, hi, av, bv, sum, t;
      modv = longint'(1) << cfg_w[c];
      av = longint'(s_a);
      bv = longint'(s_b);
      if (cfg_sg[c]) begin
        lo = -(modv / 2); hi = modv / 2 - 1;
        if (s_a[7]) av -= 256;
        if (s_b[7]) bv -= 256;
      end else begin
        lo = 0; hi = modv - 1;
      end
      if (s_av && s_bv) begin
        sum = (s_af ? 0 : m_acc[c]) + av * bv;
        if (sum > hi || sum < lo) begin
          m_ovf[c] = 1;
          if (cfg_st[c]) m_acc[c] = (sum > hi) ? hi : lo;
          else begin
            t = sum % modv;
            if (t < 0) t += modv;
            if (t > hi) t -= modv;
            m_acc[c] = t;
          end
        end else begin
          m_acc[c] = sum;
          if (s_af) m_ovf[c] = 0;
        end
      end
      if (s_av && s_bv && s_al) begin
        if (drain_shift ? drain_valid_in : m_rv[c]) m_ovr[c] = 1;
        m_res[c] = 20'(m_acc[c] & (modv - 1));
        m_rv[c]  = 1;
      end else if (drain_shift) begin
        m_res[c] = drain_in & 20'(modv - 1);
        m_rv[c]  = drain_valid_in;
      end
    end
    s_a = a_in; s_b = b_in; s_av = a_valid_in; s_af = a_first_in; s_al = a_last_in; s_bv = b_valid_in;
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      logic [19:0] r;
      logic        rv, ov, orun;
      case (c)
        0:       begin r = r0;       rv = rv0; ov = ovf0; orun = ovr0; end
        1:       begin r = r1;       rv = rv1; ov = ovf1; orun = ovr1; end
        default: begin r = 20'(r2);  rv = rv2; ov = ovf2; orun = ovr2; end
      endcase
      chk($sformatf("result[%0d]", c), r, m_res[c]);
      chk($sformatf("valid[%0d]", c), 20'(rv), 20'(m_rv[c]));
      chk($sformatf("overflow[%0d]", c), 20'(ov), 20'(m_ovf[c]));
      chk($sformatf("overrun[%0d]", c), 20'(orun), 20'(m_ovr[c]));
    end
    chk("a_out", 20'(a_out0), 20'(s_a));
    chk("b_out", 20'(b_out1), 20'(s_b));
    chk("a_fwd_ctl", 20'({av0, af0, al0}), 20'({s_av, s_af, s_al}));
    chk("b_valid_out", 20'(bv2), 20'(s_bv));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else        model_step();
    check_all();
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b,
                      input bit av, input bit bv, input bit f, input bit l);
    a_in = a; b_in = b; a_valid_in = av; b_valid_in = bv; a_first_in = f; a_last_in = l;
    cycle();
  endtask

  task automatic idle();
    a_valid_in = 0; b_valid_in = 0; a_first_in = 0; a_last_in = 0;
    cycle();
  endtask

  task automatic reset_pulse();
    reset = 0;
    #1;
    model_reset();
    check_all();
    cycle();
    reset = 1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    chk("reset_result", r0, 20'd0);
    chk("reset_valid", 20'(rv0), 20'd0);
    cycle();
    reset = 1;

    // Unsigned dot-product: 3*4 + 5*6 + 7*8 = 98
    pair(8'd3, 8'd4, 1, 1, 1, 0);
    pair(8'd5, 8'd6, 1, 1, 0, 0);
    chk("echo_a", 20'(a_out0), 20'd5);
    pair(8'd7, 8'd8, 1, 1, 0, 1);
    chk("pre_capture_valid", 20'(rv0), 20'd0);
    idle();
    chk("t1_result", r0, 20'd98);
    chk("t1_valid", 20'(rv0), 20'd1);

    // Same stream with B bubbles, including a bubble on the last-marked element
    reset_pulse();
    pair(8'd3, 8'd4, 1, 1, 1, 0);
    pair(8'd5, 8'd6, 1, 0, 0, 0);
    pair(8'd5, 8'd6, 1, 1, 0, 0);
    pair(8'd7, 8'd8, 1, 0, 0, 1);
    pair(8'd7, 8'd8, 1, 1, 0, 1);
    chk("t2_bubble_no_capture", 20'(rv0), 20'd0);
    idle();
    chk("t2_result", r0, 20'd98);

    // Signed: (-128*-128) + (-1*5) = 16379, then 127*-1 = -127
    reset_pulse();
    pair(8'h80, 8'h80, 1, 1, 1, 0);
    pair(8'hFF, 8'd5, 1, 1, 0, 1);
    idle();
    chk("t3_signed", r1, 20'd16379);
    pair(8'd127, 8'hFF, 1, 1, 1, 1);
    idle();
    chk("t3_neg", r1, 20'hFFF81);

    // Saturation at 16 bits: 2*255*255 = 130050 clamps to 65535
    reset_pulse();
    pair(8'd255, 8'd255, 1, 1, 1, 0);
    pair(8'd255, 8'd255, 1, 1, 0, 1);
    idle();
    chk("t4_sat", 20'(r2), 20'd65535);
    chk("t4_ovf", 20'(ovf2), 20'd1);
    chk("t4_wide_nosat", r0, 20'd130050);
    pair(8'd1, 8'd1, 1, 1, 1, 1);
    idle();
    chk("t4_after", 20'(r2), 20'd1);
    chk("t4_ovf_clear", 20'(ovf2), 20'd0);

    // Drain chain: shift in 0x55, then a capture colliding with a valid upstream value
    reset_pulse();
    pair(8'd3, 8'd4, 1, 1, 1, 0);
    pair(8'd5, 8'd6, 1, 1, 0, 0);
    pair(8'd7, 8'd8, 1, 1, 0, 1);
    idle();
    chk("t5_capture", r0, 20'd98);
    drain_shift = 1; drain_in = 20'h55; drain_valid_in = 1;
    idle();
    drain_shift = 0; drain_valid_in = 0;
    chk("t5_drain", r0, 20'h55);
    chk("t5_drain_valid", 20'(rv0), 20'd1);
    chk("t5_no_overrun", 20'(ovr0), 20'd0);
    pair(8'd2, 8'd3, 1, 1, 1, 1);
    drain_shift = 1; drain_in = 20'h33; drain_valid_in = 1;
    idle();
    drain_shift = 0; drain_valid_in = 0;
    chk("t5_collide_result", r0, 20'd6);
    chk("t5_overrun", 20'(ovr0), 20'd1);

    // Reset between pairs 2 and 3 swallows the stream
    reset_pulse();
    pair(8'd3, 8'd4, 1, 1, 1, 0);
    pair(8'd5, 8'd6, 1, 1, 0, 0);
    a_in = 8'd7; b_in = 8'd8; a_valid_in = 1; b_valid_in = 1; a_last_in = 1;
    reset = 0;
    #1;
    chk("t6_async_result", r0, 20'd0);
    chk("t6_async_fwd", 20'({av0, bv0}), 20'd0);
    reset_pulse();
    a_valid_in = 0; b_valid_in = 0; a_last_in = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t6_no_valid", 20'(rv0), 20'd0);
    end

    // Randomised traffic on all three configurations
    reset_pulse();
    for (int i = 0; i < 600; i++) begin
      a_in           = 8'($urandom);
      b_in           = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      a_valid_in     = ($urandom_range(0, 3) != 0);
      b_valid_in     = ($urandom_range(0, 3) != 0);
      a_first_in     = ($urandom_range(0, 4) == 0);
      a_last_in      = ($urandom_range(0, 4) == 0);
      drain_shift    = ($urandom_range(0, 3) == 0);
      drain_in       = 20'($urandom);
      drain_valid_in = ($urandom_range(0, 1) == 1);
      cycle();
      if (i == 300) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
